// File: rtl/ga_pkg.sv
// Shared GA core definitions: FSM state codes, LFSR constants
// and a constant-evaluable clog2 helper.
package ga_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEED = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [31:0] LFSR_POLY   = 32'hA3000000;
   localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lfsr_lane.sv
// One 32-bit Galois LFSR lane with seed load and zero-seed guard.
// o_word is the low WORD_W bits of the state after the coming step.
module lfsr_lane
   import ga_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [31:0]       i_seed,
   output logic [WORD_W-1:0] o_word
);

   logic [31:0] r_state;
   logic [31:0] w_next;

   // Galois right-shift step of the current state
   always_comb begin
      w_next = {1'b0, r_state[31:1]}
             ^ (r_state[0] ? LFSR_POLY : 32'h0);
   end

   assign o_word = w_next[WORD_W-1:0];

   // State register: reset to 1, seed load (never 0), or step
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= 32'h1;
      end else if (i_load) begin
         r_state <= (i_seed == 32'h0) ? 32'h1 : i_seed;
      end else if (i_step) begin
         r_state <= w_next;
      end
   end

endmodule

// File: rtl/init_pop_multi.sv
// Multi-lane LFSR population initialiser for the GA core.
// Optional macro INIT_POP_PROGRESS_EN exposes the step counter.
module init_pop_multi
   import ga_pkg::*;
#(
   parameter int POP_SIZE = 32,
   parameter int GENOME_W = 8,
   parameter int LANES    = 4,
   parameter int WORD_W   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [31:0]                  prg_seed,
   output logic [POP_SIZE*GENOME_W-1:0] population,
`ifdef INIT_POP_PROGRESS_EN
   output logic [clog2(((POP_SIZE*GENOME_W)+(LANES*WORD_W)-1)
                       /(LANES*WORD_W)+1)-1:0] fill_count,
`endif
   output logic                         busy,
   output logic                         done
);

   localparam int TOTAL  = POP_SIZE * GENOME_W;
   localparam int STEP_W = LANES * WORD_W;
   localparam int STEPS  = (TOTAL + STEP_W - 1) / STEP_W;
   localparam int CNT_W  = clog2(STEPS + 1);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [TOTAL-1:0]  r_pop;
   logic [STEP_W-1:0] w_vec;
   logic              w_load;
   logic              w_step;
   logic              w_last;

   assign w_load = (r_state == ST_SEED);
   assign w_step = (r_state == ST_FILL);
   assign w_last = (r_cnt == CNT_W'(STEPS - 1));

   // Lane i seeded with a spread of the base seed
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [31:0] LK = SEED_SPREAD * 32'(gi);
      lfsr_lane #(
         .WORD_W (WORD_W)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .i_load (w_load),
         .i_step (w_step),
         .i_seed (prg_seed ^ LK),
         .o_word (w_vec[gi*WORD_W +: WORD_W])
      );
   end

   // Control FSM, step counter and population shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pop   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) r_state <= ST_SEED;
            end
            ST_SEED: begin
               r_pop   <= '0;
               r_cnt   <= '0;
               r_state <= ST_FILL;
            end
            ST_FILL: begin
               r_pop <= TOTAL'({r_pop, w_vec});
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign population = r_pop;
   assign busy       = (r_state == ST_SEED) || (r_state == ST_FILL);
   assign done       = (r_state == ST_DONE);

`ifdef INIT_POP_PROGRESS_EN
   assign fill_count = r_cnt;
`endif

endmodule
